// File: rtl/present_p_layer_pkg.sv
// Shared PRESENT constants and the pLayer bit-index map, used by the
// forward and inverse permutation layers.
package present_pkg;

  localparam int PRESENT_BLOCK_W = 64;
  localparam int PRESENT_NIBBLES = 16;

  // Destination bit of input bit i; the top bit is the only one the
  // modulo form cannot reach, so it maps to itself explicitly.
  function automatic int p_index(input int i);
    if (i == PRESENT_BLOCK_W - 1) begin
      return i;
    end
    return (16 * i) % (PRESENT_BLOCK_W - 1);
  endfunction

endpackage

// File: rtl/present_p_layer_if.sv
// State/strobe bundle between the S-box layer (master) and the pLayer
// register (slave).
interface present_p_layer_if;
  import present_pkg::*;

  logic [PRESENT_BLOCK_W-1:0] state;
  logic                       enable_in;
  logic [PRESENT_BLOCK_W-1:0] out;
  logic                       enable_out;

  modport master (output state, output enable_in, input out, input enable_out);
  modport slave  (input state, input enable_in, output out, output enable_out);

endinterface

// File: rtl/present_p_layer_perm.sv
// Fixed 64-bit pLayer wiring, no gates. Latency: 0 (combinational).
// Backpressure: none; output follows the input continuously.
module present_p_perm
  import present_pkg::*;
(
  input  logic [PRESENT_BLOCK_W-1:0] perm_in,
  output logic [PRESENT_BLOCK_W-1:0] perm_out
);

  for (genvar i = 0; i < PRESENT_BLOCK_W; i++) begin : g_bit
    assign perm_out[p_index(i)] = perm_in[i];
  end

endmodule

// File: rtl/present_p_layer.sv
// Registered PRESENT pLayer. Latency: 1 cycle from enable_in to out/enable_out.
// Backpressure: none; every strobe is captured, back-to-back strobes allowed.
module present_p_layer
  import present_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  present_p_layer_if.slave  p_if
);

  logic [PRESENT_BLOCK_W-1:0] perm_w;
  logic [PRESENT_BLOCK_W-1:0] out_d;
  logic [PRESENT_BLOCK_W-1:0] out_q;
  logic                       enable_out_d;
  logic                       enable_out_q;

  present_p_perm u_perm (
    .perm_in  (p_if.state),
    .perm_out (perm_w)
  );

  always_comb begin
    out_d        = out_q;
    enable_out_d = p_if.enable_in;
    if (p_if.enable_in) begin
      out_d = perm_w;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q        <= '0;
      enable_out_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      enable_out_q <= enable_out_d;
    end
  end

  assign p_if.out        = out_q;
  assign p_if.enable_out = enable_out_q;

endmodule

// File: tb/tb_present_p_layer.sv
// Directed and random checks of the registered pLayer against a
// lane/nibble gather model.
module tb_present_p_layer;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  present_p_layer_if p_if ();

  present_p_layer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .p_if    (p_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output lane k, bit m takes bit k of input nibble m.
  function automatic logic [63:0] ref_perm(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int m = 0; m < 16; m++) begin
        r[16*k + m] = s[4*m + k];
      end
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_chk(input string tag, input logic [63:0] s, input logic [63:0] exp);
    p_if.state     = s;
    p_if.enable_in = 1'b1;
    step();
    chk({tag, "_out"}, p_if.out, exp);
    chk({tag, "_vld"}, {63'd0, p_if.enable_out}, 64'd1);
  endtask

  localparam logic [63:0] GOLD_IN  = 64'h7b4d942d3cbdcf1a;
  localparam logic [63:0] GOLD_OUT = 64'h597db55cc2a5d9b6;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [63:0] exp_out;
    logic [63:0] rnd;
    logic        en;
    n_cmp = 0;
    n_err = 0;

    reset_n        = 1'b0;
    p_if.state     = '0;
    p_if.enable_in = 1'b0;
    #3;
    chk("rst_out", p_if.out, 64'd0);
    chk("rst_vld", {63'd0, p_if.enable_out}, 64'd0);
    step();
    reset_n = 1'b1;

    load_chk("bit0",  64'h1, 64'h1);
    load_chk("bit1",  64'h2, 64'h0000000000010000);
    load_chk("bit4",  64'h10, 64'h2);
    load_chk("bit63", 64'h8000000000000000, 64'h8000000000000000);
    load_chk("lane16", 64'h000000000000FFFF, 64'h000F000F000F000F);
    load_chk("lane4",  64'h000000000000000F, 64'h0001000100010001);

    // Asynchronous reset mid-cycle while a strobe with all-ones is pending.
    p_if.state     = ONES;
    p_if.enable_in = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_out", p_if.out, 64'd0);
    chk("arst_vld", {63'd0, p_if.enable_out}, 64'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("arst_hold_out", p_if.out, 64'd0);
      chk("arst_hold_vld", {63'd0, p_if.enable_out}, 64'd0);
    end
    reset_n        = 1'b1;
    p_if.enable_in = 1'b0;
    step();
    chk("rel_out", p_if.out, 64'd0);

    load_chk("golden", GOLD_IN, GOLD_OUT);
    p_if.enable_in = 1'b0;
    p_if.state     = ONES;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_out", p_if.out, GOLD_OUT);
      chk("hold_vld", {63'd0, p_if.enable_out}, 64'd0);
    end
    load_chk("ones", ONES, ONES);
    load_chk("zeros", 64'd0, 64'd0);

    load_chk("b2b0", 64'h1, 64'h1);
    load_chk("b2b1", 64'h2, 64'h10000);
    load_chk("b2b2", 64'h10, 64'h2);

    exp_out = 64'h2;
    for (int n = 0; n < 1000; n++) begin
      rnd = {$urandom(), $urandom()};
      en  = 1'($urandom_range(0, 3) != 0);
      p_if.state     = rnd;
      p_if.enable_in = en;
      if (en) begin
        exp_out = ref_perm(rnd);
      end
      step();
      chk("rand_out", p_if.out, exp_out);
      chk("rand_vld", {63'd0, p_if.enable_out}, {63'd0, en});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
